// File: rtl/input_port_pkg.sv
// Shared definitions for the input port array: packet field offsets,
// credit arbiter states and the layout of the freespace credit payload.
package input_port_pkg;

  // Credit arbiter: either idle (no credit on the wire) or holding one credit.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arbState_e;

  // Credit payload layout: returning port number at the bottom, and the
  // number of freed FIFO slots in a 16-bit field directly above it.
  localparam int CREDIT_PORT_LSB   = 0;
  localparam int CREDIT_SIZE_WIDTH = 16;

  // Total packet width: {valid, leaf, port, payload}.
  function automatic int packetBits(int leafBits, int portBits, int payloadBits);
    return 1 + leafBits + portBits + payloadBits;
  endfunction

  // Bit position of the valid flag (packet MSB).
  function automatic int validPos(int leafBits, int portBits, int payloadBits);
    return leafBits + portBits + payloadBits;
  endfunction

  // LSB of the leaf address field.
  function automatic int leafLsb(int portBits, int payloadBits);
    return portBits + payloadBits;
  endfunction

  // LSB of the port address field.
  function automatic int portLsb(int payloadBits);
    return payloadBits;
  endfunction

  // LSB of the freed-slot count inside the credit payload.
  function automatic int creditSizeLsb(int portBits);
    return portBits;
  endfunction

  // Occupancy and credit counters need one bit more than the address so a
  // completely full FIFO is representable.
  function automatic int occupancyBits(int addrBits);
    return addrBits + 1;
  endfunction

endpackage

// File: rtl/input_port_fifo.sv
// One input channel: a first-word-fall-through FIFO in front of the user,
// a sticky overflow flag, and the pop/pending counters that decide when a
// freespace credit is owed back to the sender.
module input_port_fifo
  import input_port_pkg::*;
#(
  parameter int PAYLOAD_BITS = 64,
  parameter int ADDR_BITS    = 7,
  parameter int UPDATE_SIZE  = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    wr_req_i,
  input  logic [PAYLOAD_BITS-1:0] wr_data_i,
  input  logic                    ap_start_i,
  input  logic                    ack_i,
  input  logic                    grant_i,
  output logic [PAYLOAD_BITS-1:0] dout_o,
  output logic                    vld_o,
  output logic                    overflow_o,
  output logic [ADDR_BITS:0]      pending_o
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CNT_W = occupancyBits(ADDR_BITS);

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0]    wrPtr_q, wrPtr_d;
  logic [ADDR_BITS-1:0]    rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        popCnt_q, popCnt_d;
  logic [CNT_W-1:0]        pending_q, pending_d;
  logic                    overflow_q, overflow_d;

  logic isEmpty;
  logic isFull;
  logic doPop;
  logic doPush;
  logic creditDue;

  // The head is visible to the user only while the kernel is started, and a
  // pop is only honoured when the head is actually being offered.
  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == CNT_W'(DEPTH));
  assign vld_o   = !isEmpty && ap_start_i;
  assign doPop   = ack_i && vld_o;

  // A write into a full FIFO still fits when the head leaves in the same cycle.
  assign doPush  = wr_req_i && (!isFull || doPop);

  // Every UPDATE_SIZE pops free enough space to owe the sender one credit.
  assign creditDue = doPop && (popCnt_q == CNT_W'(UPDATE_SIZE - 1));

  assign dout_o     = mem_q[rdPtr_q];
  assign overflow_o = overflow_q;
  assign pending_o  = pending_q;

  // Next-state for pointers, occupancy, overflow and the credit counters.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    popCnt_d   = popCnt_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (doPush) begin
      wrPtr_d = wrPtr_q + ADDR_BITS'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + ADDR_BITS'(1);
    end

    if (doPush && !doPop) begin
      count_d = count_q + CNT_W'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - CNT_W'(1);
    end

    if (wr_req_i && !doPush) begin
      overflow_d = 1'b1;
    end

    if (creditDue) begin
      popCnt_d = '0;
    end else if (doPop) begin
      popCnt_d = popCnt_q + CNT_W'(1);
    end

    // A new credit arriving while another is granted cancels out.
    if (creditDue && !grant_i) begin
      if (pending_q != '1) begin
        pending_d = pending_q + CNT_W'(1);
      end
    end else if (grant_i && !creditDue) begin
      if (pending_q != '0) begin
        pending_d = pending_q - CNT_W'(1);
      end
    end
  end

  // Storage has no reset; stale words are never visible because occupancy is.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wr_data_i;
    end
  end

  // Control state registers, cleared asynchronously so queued data is discarded.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      popCnt_q   <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      popCnt_q   <= popCnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/input_port_array.sv
// Array of input channels fed from the leaf network. Each channel filters
// packets by its configured source {leaf, port} into its own FIFO; freed
// space is reported back through a single round-robin arbitrated credit port.
module input_port_array
  import input_port_pkg::*;
#(
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int PAYLOAD_BITS          = 64,
  parameter int NUM_IN_PORTS          = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int PORT_BASE             = 2,
  localparam int PACKET_BITS          = packetBits(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS)
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [PACKET_BITS-1:0]                              stream_in,
  input  logic [(NUM_LEAF_BITS+NUM_PORT_BITS)*NUM_IN_PORTS-1:0] in_control_reg,
  input  logic [NUM_IN_PORTS-1:0]                             port_enable,
  input  logic                                                ap_start,
  output logic [PAYLOAD_BITS*NUM_IN_PORTS-1:0]                dout2user,
  output logic [NUM_IN_PORTS-1:0]                             vld2user,
  input  logic [NUM_IN_PORTS-1:0]                             ack_user2b_in,
  output logic [PACKET_BITS-1:0]                              credit_pkt,
  input  logic                                                credit_ack,
  output logic [NUM_IN_PORTS-1:0]                             overflow
);

  localparam int CTRL_W    = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int PTR_W     = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
  localparam int VALID_POS = validPos(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
  localparam int LEAF_LSB  = leafLsb(NUM_PORT_BITS, PAYLOAD_BITS);
  localparam int PORT_LSB  = portLsb(PAYLOAD_BITS);
  localparam int SIZE_LSB  = creditSizeLsb(NUM_PORT_BITS);

  logic                     pktValid;
  logic [CTRL_W-1:0]        pktSrc;
  logic [PAYLOAD_BITS-1:0]  pktPayload;

  logic [NUM_IN_PORTS-1:0]  wrReq;
  logic [NUM_IN_PORTS-1:0]  grant;
  logic [NUM_IN_PORTS-1:0]  hasPending;
  logic [NUM_BRAM_ADDR_BITS:0] pending [NUM_IN_PORTS];

  arbState_e                arbState_q;
  logic [PTR_W-1:0]         grantIdx_q;
  logic [PACKET_BITS-1:0]   credit_q;

  logic [PTR_W-1:0]         nextIdx;
  logic [PTR_W-1:0]         candIdx;
  logic                     anyPending;
  logic [CTRL_W-1:0]        ctrlSel;
  logic [PAYLOAD_BITS-1:0]  creditPayload;
  logic [PACKET_BITS-1:0]   creditNext;

  // The source address {leaf, port} is compared as one field against each
  // channel's control slice.
  assign pktValid   = stream_in[VALID_POS];
  assign pktSrc     = {stream_in[LEAF_LSB +: NUM_LEAF_BITS], stream_in[PORT_LSB +: NUM_PORT_BITS]};
  assign pktPayload = stream_in[PAYLOAD_BITS-1:0];

  assign credit_pkt = credit_q;

  for (genvar g = 0; g < NUM_IN_PORTS; g++) begin : gChan
    // Every matching enabled channel writes, so identical control slices broadcast.
    assign wrReq[g] = pktValid && port_enable[g] &&
                      (in_control_reg[g*CTRL_W +: CTRL_W] == pktSrc);

    assign grant[g]      = (arbState_q == ARB_SEND) && credit_ack && (grantIdx_q == PTR_W'(g));
    assign hasPending[g] = (pending[g] != '0);

    input_port_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .ADDR_BITS    (NUM_BRAM_ADDR_BITS),
      .UPDATE_SIZE  (FREESPACE_UPDATE_SIZE)
    ) uFifo (
      .clk_i      (clk),
      .reset_i    (reset),
      .wr_req_i   (wrReq[g]),
      .wr_data_i  (pktPayload),
      .ap_start_i (ap_start),
      .ack_i      (ack_user2b_in[g]),
      .grant_i    (grant[g]),
      .dout_o     (dout2user[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .vld_o      (vld2user[g]),
      .overflow_o (overflow[g]),
      .pending_o  (pending[g])
    );
  end

  // Round-robin search for the next channel owed a credit, starting just
  // after the channel granted last.
  always_comb begin
    nextIdx    = grantIdx_q;
    candIdx    = grantIdx_q;
    anyPending = 1'b0;
    for (int k = 1; k <= NUM_IN_PORTS; k++) begin
      candIdx = PTR_W'((int'(grantIdx_q) + k) % NUM_IN_PORTS);
      if (!anyPending && hasPending[candIdx]) begin
        anyPending = 1'b1;
        nextIdx    = candIdx;
      end
    end
  end

  // Credit packet for the selected channel, addressed back to its source.
  always_comb begin
    ctrlSel = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (PTR_W'(i) == nextIdx) begin
        ctrlSel = in_control_reg[i*CTRL_W +: CTRL_W];
      end
    end
    creditPayload = '0;
    creditPayload[CREDIT_PORT_LSB +: NUM_PORT_BITS] = NUM_PORT_BITS'(PORT_BASE + int'(nextIdx));
    creditPayload[SIZE_LSB +: CREDIT_SIZE_WIDTH]    = CREDIT_SIZE_WIDTH'(FREESPACE_UPDATE_SIZE);
    creditNext = {1'b1, ctrlSel, creditPayload};
  end

  // Credit arbiter: latch one credit, hold it until accepted, then spend one
  // idle cycle before looking for the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arbState_q <= ARB_IDLE;
      grantIdx_q <= PTR_W'(NUM_IN_PORTS - 1);
      credit_q   <= '0;
    end else begin
      case (arbState_q)
        ARB_IDLE: begin
          if (anyPending) begin
            arbState_q <= ARB_SEND;
            grantIdx_q <= nextIdx;
            credit_q   <= creditNext;
          end
        end
        ARB_SEND: begin
          if (credit_ack) begin
            arbState_q <= ARB_IDLE;
            credit_q   <= '0;
          end
        end
        default: begin
          arbState_q <= ARB_IDLE;
          credit_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_array.sv
// Self-checking bench for input_port_array: directed scenarios plus a
// randomized traffic run against a queue-based reference model.
module tb_input_port_array;

  localparam int L     = 6;
  localparam int P     = 4;
  localparam int W     = 64;
  localparam int N     = 7;
  localparam int A     = 7;
  localparam int SZ    = 64;
  localparam int PB    = 2;
  localparam int PKT   = 1 + L + P + W;
  localparam int CW    = L + P;
  localparam int DEPTH = 2 ** A;

  logic             clk;
  logic             reset;
  logic [PKT-1:0]   stream_in;
  logic [CW*N-1:0]  in_control_reg;
  logic [N-1:0]     port_enable;
  logic             ap_start;
  logic [W*N-1:0]   dout2user;
  logic [N-1:0]     vld2user;
  logic [N-1:0]     ack_user2b_in;
  logic [PKT-1:0]   credit_pkt;
  logic             credit_ack;
  logic [N-1:0]     overflow;

  int checks;
  int errors;

  int ctrlLeaf [N];
  int ctrlPort [N];

  logic [W-1:0] modelQ [N][$];
  int           modelPops [N];
  bit           modelOvf [N];

  input_port_array #(
    .NUM_LEAF_BITS         (L),
    .NUM_PORT_BITS         (P),
    .PAYLOAD_BITS          (W),
    .NUM_IN_PORTS          (N),
    .NUM_BRAM_ADDR_BITS    (A),
    .FREESPACE_UPDATE_SIZE (SZ),
    .PORT_BASE             (PB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stream_in      (stream_in),
    .in_control_reg (in_control_reg),
    .port_enable    (port_enable),
    .ap_start       (ap_start),
    .dout2user      (dout2user),
    .vld2user       (vld2user),
    .ack_user2b_in  (ack_user2b_in),
    .credit_pkt     (credit_pkt),
    .credit_ack     (credit_ack),
    .overflow       (overflow)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [PKT-1:0] makePkt(input int leaf, input int port, input logic [W-1:0] pl);
    return {1'b1, L'(leaf), P'(port), pl};
  endfunction

  // Credit expected for channel ch, built from the documented layout.
  function automatic logic [PKT-1:0] expCredit(input int ch);
    logic [W-1:0] pl;
    pl        = '0;
    pl[3:0]   = 4'(PB + ch);
    pl[19:4]  = 16'(SZ);
    return {1'b1, L'(ctrlLeaf[ch]), P'(ctrlPort[ch]), pl};
  endfunction

  function automatic logic [W-1:0] doutOf(input int ch);
    return dout2user[ch*W +: W];
  endfunction

  task automatic applyCtrl();
    for (int i = 0; i < N; i++) begin
      in_control_reg[i*CW +: CW] = {L'(ctrlLeaf[i]), P'(ctrlPort[i])};
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset         = 1'b1;
    stream_in     = '0;
    port_enable   = '1;
    ap_start      = 1'b0;
    ack_user2b_in = '0;
    credit_ack    = 1'b0;
    for (int i = 0; i < N; i++) begin
      modelQ[i].delete();
      modelPops[i] = 0;
      modelOvf[i]  = 1'b0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic writeWords(input int ch, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      stream_in = makePkt(ctrlLeaf[ch], ctrlPort[ch], W'(base + k));
      nextCycle();
    end
    stream_in = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #2;
    checks++;
    if (vld2user !== '0 || credit_pkt !== '0 || overflow !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async: vld=%b credit=%h ovf=%b, required all zero", vld2user, credit_pkt, overflow);
    end
    ap_start  = 1'b1;
    stream_in = makePkt(ctrlLeaf[0], ctrlPort[0], 64'h77);
    nextCycle();
    @(negedge clk);
    checks++;
    if (vld2user !== '0 || credit_pkt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_held: vld=%b credit=%h, required zero", vld2user, credit_pkt);
    end
    doReset();
  endtask

  task automatic test_single_packet();
    doReset();
    ap_start  = 1'b1;
    stream_in = makePkt(3, 5, 64'hA5);
    @(negedge clk);
    checks++;
    if (vld2user !== '0) begin
      errors++;
      $display("[TB] FAIL single_before: vld=%b required 0", vld2user);
    end
    nextCycle();
    stream_in = '0;
    @(negedge clk);
    checks++;
    if (vld2user !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL single_vld: vld=%b required 0000001", vld2user);
    end
    checks++;
    if (doutOf(0) !== 64'hA5) begin
      errors++;
      $display("[TB] FAIL single_dout: got %h required a5", doutOf(0));
    end
    ack_user2b_in = 7'b1;
    nextCycle();
    ack_user2b_in = '0;
    @(negedge clk);
    checks++;
    if (vld2user !== '0) begin
      errors++;
      $display("[TB] FAIL single_popped: vld=%b required 0", vld2user);
    end
  endtask

  task automatic test_broadcast();
    int saveL4, saveP4, saveL5, saveP5;
    saveL4 = ctrlLeaf[4]; saveP4 = ctrlPort[4];
    saveL5 = ctrlLeaf[5]; saveP5 = ctrlPort[5];
    ctrlLeaf[4] = 40; ctrlPort[4] = 13;
    ctrlLeaf[5] = 40; ctrlPort[5] = 13;
    applyCtrl();
    doReset();
    ap_start  = 1'b1;
    stream_in = makePkt(40, 13, 64'h1111);
    nextCycle();
    port_enable = 7'b1011111;
    stream_in   = makePkt(40, 13, 64'h2222);
    @(negedge clk);
    checks++;
    if (vld2user !== 7'b0110000 || doutOf(4) !== 64'h1111 || doutOf(5) !== 64'h1111) begin
      errors++;
      $display("[TB] FAIL bcast_both: vld=%b d4=%h d5=%h required 0110000 1111 1111", vld2user, doutOf(4), doutOf(5));
    end
    nextCycle();
    stream_in     = '0;
    port_enable   = '1;
    ack_user2b_in = 7'b0110000;
    nextCycle();
    ack_user2b_in = '0;
    @(negedge clk);
    checks++;
    if (vld2user !== 7'b0010000 || doutOf(4) !== 64'h2222) begin
      errors++;
      $display("[TB] FAIL bcast_enable: vld=%b d4=%h required 0010000 2222", vld2user, doutOf(4));
    end
    ctrlLeaf[4] = saveL4; ctrlPort[4] = saveP4;
    ctrlLeaf[5] = saveL5; ctrlPort[5] = saveP5;
    applyCtrl();
  endtask

  task automatic test_random_traffic();
    int           credits [N];
    int           ch;
    int           r;
    int           cnum;
    logic [W-1:0] pl;
    logic [PKT-1:0] pkt;
    logic [N-1:0] en;
    logic [N-1:0] ack;
    bit           expV;
    bit           full;
    bit           pop;
    bit           wr;
    doReset();
    for (int i = 0; i < N; i++) credits[i] = 0;
    en  = '1;
    pkt = '0;
    ack = '0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc < 750) begin
        if (cyc % 40 == 0) en = N'($urandom) | N'($urandom);
        ap_start   = ($urandom % 4) != 0;
        ack        = N'($urandom);
        credit_ack = ($urandom % 2) != 0;
        r  = $urandom % 8;
        ch = ($urandom % 4 == 0) ? int'($urandom % N) : int'($urandom % 2);
        pl = {$urandom, $urandom};
        if (r <= 4) begin
          pkt = makePkt(ctrlLeaf[ch], ctrlPort[ch], pl);
        end else if (r == 5) begin
          pkt = makePkt(63, 15, pl);
        end else if (r == 6) begin
          pkt = makePkt(ctrlLeaf[ch], ctrlPort[ch], pl);
          pkt[PKT-1] = 1'b0;
        end else begin
          pkt = '0;
        end
      end else begin
        ap_start   = 1'b1;
        ack        = '0;
        pkt        = '0;
        credit_ack = 1'b1;
      end
      port_enable   = en;
      ack_user2b_in = ack;
      stream_in     = pkt;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        expV = (modelQ[i].size() != 0) && ap_start;
        checks++;
        if (vld2user[i] !== expV) begin
          errors++;
          $display("[TB] FAIL rand_vld ch%0d cyc%0d: got %b required %b", i, cyc, vld2user[i], expV);
        end
        if (modelQ[i].size() != 0) begin
          checks++;
          if (doutOf(i) !== modelQ[i][0]) begin
            errors++;
            $display("[TB] FAIL rand_dout ch%0d cyc%0d: got %h required %h", i, cyc, doutOf(i), modelQ[i][0]);
          end
        end
        checks++;
        if (overflow[i] !== modelOvf[i]) begin
          errors++;
          $display("[TB] FAIL rand_ovf ch%0d cyc%0d: got %b required %b", i, cyc, overflow[i], modelOvf[i]);
        end
      end
      if (credit_pkt[PKT-1] === 1'b1 && credit_ack) begin
        cnum = int'(credit_pkt[3:0]) - PB;
        checks++;
        if (cnum < 0 || cnum >= N) begin
          errors++;
          $display("[TB] FAIL rand_credit_port: got port field %0d required %0d..%0d", credit_pkt[3:0], PB, PB + N - 1);
        end else if (credit_pkt !== expCredit(cnum)) begin
          errors++;
          $display("[TB] FAIL rand_credit_pkt: got %h required %h", credit_pkt, expCredit(cnum));
        end else begin
          credits[cnum]++;
        end
      end
      for (int i = 0; i < N; i++) begin
        expV = (modelQ[i].size() != 0) && ap_start;
        full = (modelQ[i].size() == DEPTH);
        pop  = ack[i] && expV;
        wr   = pkt[PKT-1] && en[i] && (pkt[PKT-2 -: CW] == {L'(ctrlLeaf[i]), P'(ctrlPort[i])});
        if (pop) begin
          void'(modelQ[i].pop_front());
          modelPops[i]++;
        end
        if (wr) begin
          if (!full || pop) modelQ[i].push_back(pkt[W-1:0]);
          else modelOvf[i] = 1'b1;
        end
      end
      nextCycle();
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (credits[i] != modelPops[i] / SZ) begin
        errors++;
        $display("[TB] FAIL rand_credit_count ch%0d: got %0d required %0d", i, credits[i], modelPops[i] / SZ);
      end
    end
  endtask

  task automatic test_overflow();
    doReset();
    writeWords(1, DEPTH, 0);
    @(negedge clk);
    checks++;
    if (vld2user !== '0 || overflow !== '0) begin
      errors++;
      $display("[TB] FAIL ovf_full_state: vld=%b ovf=%b required 0 0", vld2user, overflow);
    end
    nextCycle();
    writeWords(1, 1, 999);
    @(negedge clk);
    checks++;
    if (overflow !== 7'b0000010) begin
      errors++;
      $display("[TB] FAIL ovf_drop_flag: got %b required 0000010", overflow);
    end
    nextCycle();
    ap_start      = 1'b1;
    ack_user2b_in = 7'b0000010;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      checks++;
      if (vld2user[1] !== 1'b1 || doutOf(1) !== W'(k)) begin
        errors++;
        $display("[TB] FAIL ovf_drain word%0d: vld=%b dout=%h required 1 %h", k, vld2user[1], doutOf(1), W'(k));
      end
      nextCycle();
    end
    ack_user2b_in = '0;
    @(negedge clk);
    checks++;
    if (vld2user[1] !== 1'b0 || overflow !== 7'b0000010) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: vld=%b ovf=%b required 0 0000010", vld2user[1], overflow);
    end

    doReset();
    writeWords(1, DEPTH, 0);
    stream_in     = makePkt(ctrlLeaf[1], ctrlPort[1], W'(DEPTH));
    ap_start      = 1'b1;
    ack_user2b_in = 7'b0000010;
    @(negedge clk);
    checks++;
    if (doutOf(1) !== '0) begin
      errors++;
      $display("[TB] FAIL ovf_pop_head: got %h required 0", doutOf(1));
    end
    nextCycle();
    stream_in = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      checks++;
      if (vld2user[1] !== 1'b1 || doutOf(1) !== W'(k) || overflow !== '0) begin
        errors++;
        $display("[TB] FAIL ovf_accept word%0d: vld=%b dout=%h ovf=%b required 1 %h 0", k, vld2user[1], doutOf(1), overflow, W'(k));
      end
      nextCycle();
    end
    ack_user2b_in = '0;
    @(negedge clk);
    checks++;
    if (vld2user[1] !== 1'b0 || overflow !== '0) begin
      errors++;
      $display("[TB] FAIL ovf_accept_end: vld=%b ovf=%b required 0 0", vld2user[1], overflow);
    end
  endtask

  task automatic test_credit_hold();
    logic [PKT-1:0] exp;
    bit             seen;
    doReset();
    writeWords(2, SZ, 0);
    ap_start      = 1'b1;
    ack_user2b_in = 7'b0000100;
    for (int k = 0; k < SZ; k++) begin
      @(negedge clk);
      checks++;
      if (credit_pkt[PKT-1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL credit_early pop%0d: valid=%b required 0", k, credit_pkt[PKT-1]);
      end
      nextCycle();
    end
    ack_user2b_in = '0;
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      if (credit_pkt[PKT-1] === 1'b1) seen = 1'b1;
      else nextCycle();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL credit_timeout: valid=%b required 1 within 8 cycles", credit_pkt[PKT-1]);
    end
    exp = expCredit(2);
    checks++;
    if (credit_pkt !== exp) begin
      errors++;
      $display("[TB] FAIL credit_content: got %h required %h", credit_pkt, exp);
    end
    for (int t = 0; t < 5; t++) begin
      nextCycle();
      @(negedge clk);
      checks++;
      if (credit_pkt !== exp) begin
        errors++;
        $display("[TB] FAIL credit_hold cyc%0d: got %h required %h", t, credit_pkt, exp);
      end
    end
    nextCycle();
    credit_ack = 1'b1;
    nextCycle();
    credit_ack = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      checks++;
      if (credit_pkt !== '0) begin
        errors++;
        $display("[TB] FAIL credit_after_ack cyc%0d: got %h required 0", t, credit_pkt);
      end
      nextCycle();
    end
  endtask

  task automatic test_round_robin();
    int             order [3];
    int             gotCyc [$];
    logic [PKT-1:0] gotPkt [$];
    order = '{0, 3, 6};
    doReset();
    writeWords(0, SZ, 0);
    writeWords(3, SZ, 0);
    writeWords(6, SZ, 0);
    ap_start      = 1'b1;
    credit_ack    = 1'b1;
    ack_user2b_in = 7'b1001001;
    repeat (SZ) nextCycle();
    ack_user2b_in = '0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (credit_pkt[PKT-1] === 1'b1) begin
        gotCyc.push_back(t);
        gotPkt.push_back(credit_pkt);
      end
      nextCycle();
    end
    checks++;
    if (gotCyc.size() != 3) begin
      errors++;
      $display("[TB] FAIL rr_count: got %0d credit cycles required 3", gotCyc.size());
    end
    for (int j = 0; j < 3; j++) begin
      if (j < gotPkt.size()) begin
        checks++;
        if (gotPkt[j] !== expCredit(order[j])) begin
          errors++;
          $display("[TB] FAIL rr_order grant%0d: got %h required %h", j, gotPkt[j], expCredit(order[j]));
        end
        if (j > 0) begin
          checks++;
          if (gotCyc[j] - gotCyc[j-1] != 2) begin
            errors++;
            $display("[TB] FAIL rr_gap grant%0d: got %0d cycles required 2", j, gotCyc[j] - gotCyc[j-1]);
          end
        end
      end
    end
  endtask

  task automatic test_apstart_reset();
    bit seen;
    doReset();
    writeWords(0, 3, 256);
    ap_start      = 1'b0;
    ack_user2b_in = 7'b0000001;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checks++;
      if (vld2user !== '0) begin
        errors++;
        $display("[TB] FAIL gate_vld cyc%0d: got %b required 0", t, vld2user);
      end
      nextCycle();
    end
    ack_user2b_in = '0;
    ap_start      = 1'b1;
    @(negedge clk);
    checks++;
    if (vld2user !== 7'b0000001 || doutOf(0) !== 64'd256) begin
      errors++;
      $display("[TB] FAIL gate_ack_ignored: vld=%b dout=%h required 0000001 100", vld2user, doutOf(0));
    end
    nextCycle();
    writeWords(5, SZ, 0);
    ack_user2b_in = 7'b0100000;
    repeat (SZ) nextCycle();
    ack_user2b_in = '0;
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      if (credit_pkt[PKT-1] === 1'b1) seen = 1'b1;
      else nextCycle();
    end
    checks++;
    if (!seen || credit_pkt !== expCredit(5)) begin
      errors++;
      $display("[TB] FAIL send_before_reset: got %h required %h", credit_pkt, expCredit(5));
    end
    reset = 1'b1;
    #1;
    checks++;
    if (credit_pkt !== '0 || vld2user !== '0 || overflow !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_send: credit=%h vld=%b ovf=%b required all zero", credit_pkt, vld2user, overflow);
    end
    nextCycle();
    reset      = 1'b0;
    credit_ack = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      checks++;
      if (credit_pkt !== '0 || vld2user !== '0) begin
        errors++;
        $display("[TB] FAIL after_reset cyc%0d: credit=%h vld=%b required 0 0", t, credit_pkt, vld2user);
      end
      nextCycle();
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    stream_in     = '0;
    port_enable   = '1;
    ap_start      = 1'b0;
    ack_user2b_in = '0;
    credit_ack    = 1'b0;
    for (int i = 0; i < N; i++) begin
      ctrlLeaf[i] = 3 + 5 * i;
      ctrlPort[i] = 5 + i;
    end
    applyCtrl();
    test_reset();
    test_single_packet();
    test_broadcast();
    test_random_traffic();
    test_overflow();
    test_credit_hold();
    test_round_robin();
    test_apstart_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
